// File: rtl/prog_mem_loader.sv
// Writable CPU program memory filled through a byte-wide valid/ready loader port.
// Fetch data registered on negedge clk (half-cycle latency); loader stalls via load_ready during WRITE/DONE.
module prog_mem_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  cpu_stall,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int DEPTH          = 1 << ADDR_WIDTH;
  localparam int BIW            = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIW-1:0]        byte_idx_q;
  logic [ADDR_WIDTH:0]   wr_ptr_q;
  logic                  last_q;
  logic                  ready_q;
  logic                  stall_q;
  logic                  done_q;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  mem_we_d;

  // Power-up contents are all NOPs; reset deliberately leaves the array alone.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      byte_idx_q <= '0;
      wr_ptr_q   <= '0;
      last_q     <= 1'b0;
      ready_q    <= 1'b0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (load_start) begin
      // A restart abandons any partial or pending word.
      state_q    <= COLLECT;
      shift_q    <= '0;
      byte_idx_q <= '0;
      wr_ptr_q   <= '0;
      last_q     <= 1'b0;
      ready_q    <= 1'b1;
      stall_q    <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          stall_q <= 1'b0;
          done_q  <= 1'b0;
        end
        COLLECT: begin
          if (load_valid && ready_q) begin
            shift_q[byte_idx_q*8 +: 8] <= load_byte;
            if (byte_idx_q == BIW'(BYTES_PER_WORD - 1) || load_last) begin
              state_q <= WRITE;
              ready_q <= 1'b0;
              last_q  <= load_last;
            end else begin
              byte_idx_q <= byte_idx_q + BIW'(1);
            end
          end
        end
        WRITE: begin
          // Pointer saturates at DEPTH so the start of the image is never overwritten.
          if (!wr_ptr_q[ADDR_WIDTH]) begin
            wr_ptr_q <= wr_ptr_q + (ADDR_WIDTH + 1)'(1);
          end else begin
            overflow_q <= 1'b1;
          end
          shift_q    <= '0;
          byte_idx_q <= '0;
          if (last_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= COLLECT;
            ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          stall_q <= 1'b0;
          ready_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_we_d = (state_q == WRITE) && !reset && !load_start && !wr_ptr_q[ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= shift_q;
    end
  end

  // The CPU sees NOPs whenever the loader owns the array.
  assign data_d = (state_q == IDLE) ? mem_q[addr] : '0;

  always_ff @(negedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data         = data_q;
  assign cpu_stall    = stall_q;
  assign load_ready   = ready_q;
  assign load_done    = done_q;
  assign overflow     = overflow_q;
  assign words_loaded = wr_ptr_q;

endmodule
